perf_counter_wb: RTL and testbench



---
 rtl/perf_counter_wb_if.sv | 22 ++
 rtl/perf_counter_wb.sv | 93 +++++++++
 tb/tb_perf_counter_wb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_wb_if.sv
// Writeback-stage control and display readout bundle for perf_counter_wb.
interface perf_counter_wb_if #(
  parameter int unsigned WIDTH = 16
);
  logic [3:0]       wb_opcode;
  logic             ir4_load;
  logic             stop;
  logic [2:0]       sel;
  logic [WIDTH-1:0] count_out;
  logic             halted;
  logic             overflow;

  modport master (
    output wb_opcode, ir4_load, stop, sel,
    input  count_out, halted, overflow
  );

  modport slave (
    input  wb_opcode, ir4_load, stop, sel,
    output count_out, halted, overflow
  );
endinterface

// File: rtl/perf_counter_wb.sv
// Saturating cycle/retired/bubble counters frozen at STOP, with registered readout.
// Optional per-class counters (loads/stores/branches) enabled by PERF_CLASS_COUNT_EN.
module perf_counter_wb #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clock,
  input logic             reset,
  perf_counter_wb_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STOP  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_NOP   = 4'd10;

  state_t           state;
  logic [WIDTH-1:0] cycles, retired, bubbles, count_q;
  logic             ovf_q;
  logic             run, completes, inc_ret, inc_bub, wrap;
  logic [WIDTH-1:0] sel_val;

`ifdef PERF_CLASS_COUNT_EN
  logic [WIDTH-1:0] loads, stores, branches;
  logic             class_ok, inc_ld, inc_st, inc_br;
`endif

  always_comb begin
    run       = (state == RUN);
    completes = bus.ir4_load && (bus.wb_opcode != OP_NOP) && (bus.wb_opcode != OP_STOP);
    // A stop cycle only counts as a cycle, never as retired or bubble.
    inc_ret   = run && !bus.stop && completes;
    inc_bub   = run && !bus.stop && !completes;
    wrap      = (run && (&cycles)) || (inc_ret && (&retired)) || (inc_bub && (&bubbles));
`ifdef PERF_CLASS_COUNT_EN
    class_ok  = run && !bus.stop && bus.ir4_load;
    inc_ld    = class_ok && (bus.wb_opcode == OP_LOAD);
    inc_st    = class_ok && (bus.wb_opcode == OP_STORE);
    inc_br    = class_ok && ((bus.wb_opcode == 4'd5) || (bus.wb_opcode == 4'd9) ||
                             (bus.wb_opcode == 4'd13));
    wrap      = wrap || (inc_ld && (&loads)) || (inc_st && (&stores)) || (inc_br && (&branches));
`endif
  end

  always_comb begin
    sel_val = '0;
    case (bus.sel)
      3'd0: sel_val = cycles;
      3'd1: sel_val = retired;
      3'd2: sel_val = bubbles;
`ifdef PERF_CLASS_COUNT_EN
      3'd3: sel_val = loads;
      3'd4: sel_val = stores;
      3'd5: sel_val = branches;
`endif
      default: sel_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      cycles   <= '0;
      retired  <= '0;
      bubbles  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef PERF_CLASS_COUNT_EN
      loads    <= '0;
      stores   <= '0;
      branches <= '0;
`endif
    end else begin
      count_q <= sel_val;
      if (wrap) ovf_q <= 1'b1;
      if (run) begin
        if (!(&cycles)) cycles <= cycles + WIDTH'(1);
        if (bus.stop) state <= HALTED;
      end
      if (inc_ret && !(&retired)) retired <= retired + WIDTH'(1);
      if (inc_bub && !(&bubbles)) bubbles <= bubbles + WIDTH'(1);
`ifdef PERF_CLASS_COUNT_EN
      if (inc_ld && !(&loads))    loads    <= loads + WIDTH'(1);
      if (inc_st && !(&stores))   stores   <= stores + WIDTH'(1);
      if (inc_br && !(&branches)) branches <= branches + WIDTH'(1);
`endif
    end
  end

  assign bus.count_out = count_q;
  assign bus.halted    = (state == HALTED);
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_perf_counter_wb.sv
// Bench for perf_counter_wb: a 16-bit and a 4-bit instance share one stimulus stream
// and are checked each cycle against unbounded event counts clamped to each width.
module tb_perf_counter_wb;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       ld, stp;
  logic [2:0] sel;

  perf_counter_wb_if #(.WIDTH(16)) bus16();
  perf_counter_wb_if #(.WIDTH(4))  bus4();

  assign bus16.wb_opcode = op;
  assign bus16.ir4_load  = ld;
  assign bus16.stop      = stp;
  assign bus16.sel       = sel;
  assign bus4.wb_opcode  = op;
  assign bus4.ir4_load   = ld;
  assign bus4.stop       = stp;
  assign bus4.sel        = sel;

  perf_counter_wb #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
  perf_counter_wb #(.WIDTH(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;
  int m_cyc, m_ret, m_bub, m_ld, m_st, m_br;
  bit m_halt;
  int exp16, exp4;

`ifdef PERF_CLASS_COUNT_EN
  localparam bit CLASS_EN = 1'b1;
`else
  localparam bit CLASS_EN = 1'b0;
`endif

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int pick(int s, int mx);
    case (s)
      0: return sat(m_cyc, mx);
      1: return sat(m_ret, mx);
      2: return sat(m_bub, mx);
      3: return CLASS_EN ? sat(m_ld, mx) : 0;
      4: return CLASS_EN ? sat(m_st, mx) : 0;
      5: return CLASS_EN ? sat(m_br, mx) : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int ovf(int mx);
    if (m_cyc > mx || m_ret > mx || m_bub > mx) return 1;
    if (CLASS_EN && (m_ld > mx || m_st > mx || m_br > mx)) return 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int exp);
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the event-count model from the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clock);
    if (reset) begin
      m_cyc = 0; m_ret = 0; m_bub = 0; m_ld = 0; m_st = 0; m_br = 0;
      m_halt = 1'b0; exp16 = 0; exp4 = 0;
    end else begin
      exp16 = pick(int'(sel), 65535);
      exp4  = pick(int'(sel), 15);
      if (!m_halt) begin
        m_cyc++;
        if (stp) m_halt = 1'b1;
        else begin
          if (ld && op != 4'd10 && op != 4'd1) m_ret++;
          else m_bub++;
          if (ld) begin
            if (op == 4'd0) m_ld++;
            if (op == 4'd2) m_st++;
            if (op inside {4'd5, 4'd9, 4'd13}) m_br++;
          end
        end
      end
    end
    @(negedge clock);
    n_vec++;
    chk("halted16",   bus16.halted,    int'(m_halt));
    chk("overflow16", bus16.overflow,  ovf(65535));
    chk("count16",    bus16.count_out, exp16);
    chk("halted4",    bus4.halted,     int'(m_halt));
    chk("overflow4",  bus4.overflow,   ovf(15));
    chk("count4",     bus4.count_out,  exp4);
  endtask

  task automatic run_n(int n, logic [3:0] o, logic l, logic s);
    op = o; ld = l; stp = s;
    repeat (n) step();
  endtask

  task automatic rd(logic [2:0] s, int exp, string tag);
    sel = s; ld = 1'b0; stp = 1'b0;
    step();
    chk(tag, bus16.count_out, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; ld = 1'b0; stp = 1'b0; op = 4'd10; sel = 3'd0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 4'd10; ld = 1'b0; stp = 1'b0; sel = 3'd0;
    step();
    step();
    reset = 1'b0;
    chk("rst_count", bus16.count_out, 0);
    chk("rst_halted", bus16.halted, 0);

    // 10 ADDs then STOP
    run_n(10, 4'd4, 1'b1, 1'b0);
    run_n(1, 4'd1, 1'b1, 1'b1);
    chk("add_halted", bus16.halted, 1);
    rd(3'd0, 11, "add_cycles");
    rd(3'd1, 10, "add_retired");
    rd(3'd2, 0,  "add_bubbles");

    // mixed stream, then random inputs while halted
    do_reset();
    run_n(3, 4'd10, 1'b1, 1'b0);
    run_n(2, 4'd0,  1'b0, 1'b0);
    run_n(4, 4'd7,  1'b1, 1'b0);
    run_n(1, 4'd1,  1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom); ld = 1'($urandom); stp = 1'($urandom); sel = 3'($urandom);
      step();
    end
    rd(3'd0, 10, "mix_cycles");
    rd(3'd1, 4,  "mix_retired");
    rd(3'd2, 5,  "mix_bubbles");

    // sel toggle latency in HALTED, then reset while halted
    rd(3'd0, 10, "sel_before");
    sel = 3'd1;
    chk("sel_hold", bus16.count_out, 10);
    step();
    chk("sel_after", bus16.count_out, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rsth_halted", bus16.halted, 0);
    chk("rsth_count", bus16.count_out, 0);
    chk("rsth_ovf", bus4.overflow, 0);
    rd(3'd0, 0, "rsth_cycles");
    rd(3'd1, 0, "rsth_retired");

    // STOP coincident with ir4_load
    do_reset();
    run_n(3, 4'd4, 1'b1, 1'b0);
    run_n(1, 4'd1, 1'b1, 1'b1);
    chk("stopld_halted", bus16.halted, 1);
    rd(3'd0, 4, "stopld_cycles");
    rd(3'd1, 3, "stopld_retired");
    rd(3'd2, 0, "stopld_bubbles");

    // saturation on the 4-bit instance
    do_reset();
    sel = 3'd0;
    run_n(15, 4'd4, 1'b1, 1'b0);
    chk("sat_ovf_before", bus4.overflow, 0);
    step();
    chk("sat_ovf_rise", bus4.overflow, 1);
    repeat (4) step();
    chk("sat_ovf_stay", bus4.overflow, 1);
    chk("sat_cycles4", bus4.count_out, 15);
    do_reset();
    chk("sat_ovf_clear", bus4.overflow, 0);

    // instruction classes
    do_reset();
    run_n(2, 4'd0,  1'b1, 1'b0);
    run_n(3, 4'd2,  1'b1, 1'b0);
    run_n(1, 4'd5,  1'b1, 1'b0);
    run_n(1, 4'd9,  1'b1, 1'b0);
    run_n(1, 4'd13, 1'b1, 1'b0);
    run_n(1, 4'd1,  1'b1, 1'b1);
    rd(3'd3, CLASS_EN ? 2 : 0, "cls_loads");
    rd(3'd4, CLASS_EN ? 3 : 0, "cls_stores");
    rd(3'd5, CLASS_EN ? 3 : 0, "cls_branches");
    rd(3'd6, 0, "cls_sel6");
    rd(3'd1, 8, "cls_retired");

    // random traffic with occasional stop and reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      stp   = ($urandom_range(0, 24) == 0);
      op    = 4'($urandom);
      ld    = 1'($urandom);
      sel   = 3'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
